// File: rtl/fgen_capture.sv
// fgen_capture: records slave bus writes inside a triggered capture window.
// Each entry holds {timestamp, address, data} and goes into a first-word-fall-through FIFO
// that the host drains with a pop handshake.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   arm                  - one-cycle command: empty the FIFO, clear the flags, go to ARMED
//   trig, win_len        - start of the capture window and its length in cycles
//   lbo_write/addr/data  - slave bus write being observed
//   collision            - generator collision flag, latched into coll_seen during CAPTURE
//   pop                  - host consumes the head entry
//   q_valid, q_time, q_addr, q_data - head entry of the FIFO
//   count, overflow, coll_seen, state - status outputs
module fgen_capture #(
    parameter int unsigned aw = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          trig,
    input  logic [15:0]   win_len,
    input  logic          lbo_write,
    input  logic [15:0]   lbo_addr,
    input  logic [31:0]   lbo_data,
    input  logic          collision,
    input  logic          pop,
    output logic          q_valid,
    output logic [15:0]   q_time,
    output logic [15:0]   q_addr,
    output logic [31:0]   q_data,
    output logic [aw:0]   count,
    output logic          overflow,
    output logic          coll_seen,
    output logic [1:0]    state
);

    localparam int unsigned DEPTH = 1 << aw;
    localparam int unsigned EW    = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e          state_q;
    logic [15:0]     timer_q;
    logic [15:0]     win_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [aw-1:0]   wr_ptr_q;
    logic [aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [aw:0]     count_q, count_d;
    logic [EW-1:0]   head_q, head_d;
    logic            valid_q;
    logic            overflow_q;
    logic            coll_q;

    logic            full;
    logic            capture_c;
    logic            pop_eff;
    logic            push_eff;
    logic            drop;
    logic [EW-1:0]   push_entry;

    // Push/pop qualification and next head entry of the FIFO.
    always_comb begin
        full       = (count_q == (aw+1)'(DEPTH));
        capture_c  = lbo_write && ((state_q == ST_ARMED && trig) || state_q == ST_CAPTURE);
        // A write in the trigger cycle itself is stamped 0.
        push_entry = {(state_q == ST_CAPTURE) ? timer_q : 16'd0, lbo_addr, lbo_data};
        pop_eff    = pop && (count_q != '0) && !arm;
        push_eff   = capture_c && !arm && (!full || pop_eff);
        drop       = capture_c && !arm && full && !pop_eff;
        rd_ptr_d   = rd_ptr_q + aw'(pop_eff);
        count_d    = count_q + (aw+1)'(push_eff) - (aw+1)'(pop_eff);
        head_d     = head_q;
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_eff && ((count_q - (aw+1)'(pop_eff)) == '0)) begin
            // The FIFO is empty after this cycle's pop, so the pushed entry becomes the head.
            head_d = push_entry;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage; needs no reset because the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Control FSM, pointers, flags and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            win_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            coll_q     <= 1'b0;
        end else if (arm) begin
            state_q    <= ST_ARMED;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + aw'(push_eff);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (state_q == ST_CAPTURE && collision) begin
                coll_q <= 1'b1;
            end
            case (state_q)
                ST_ARMED: begin
                    if (trig) begin
                        win_q   <= win_len;
                        timer_q <= 16'd1;
                        // A zero-length window ends on the trigger cycle.
                        state_q <= (win_len == 16'd0) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (timer_q == win_q) begin
                        state_q <= ST_DONE;
                    end else if (timer_q != 16'hFFFF) begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q_valid   = valid_q;
    assign q_time    = head_q[63:48];
    assign q_addr    = head_q[47:32];
    assign q_data    = head_q[31:0];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign coll_seen = coll_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fgen_capture.sv
// Scoreboard bench for fgen_capture (aw=2, depth 4). Stimulus pushes the expected entries;
// a monitor on the falling edge compares the head each time the host pops it.
module tb_fgen_capture;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [15:0]   win_len = '0;
    logic          lbo_write = 1'b0;
    logic [15:0]   lbo_addr = '0;
    logic [31:0]   lbo_data = '0;
    logic          collision = 1'b0;
    logic          pop = 1'b0;
    logic          q_valid;
    logic [15:0]   q_time;
    logic [15:0]   q_addr;
    logic [31:0]   q_data;
    logic [AW:0]   count;
    logic          overflow;
    logic          coll_seen;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    fgen_capture #(.aw(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .win_len(win_len),
        .lbo_write(lbo_write), .lbo_addr(lbo_addr), .lbo_data(lbo_data),
        .collision(collision), .pop(pop), .q_valid(q_valid), .q_time(q_time),
        .q_addr(q_addr), .q_data(q_data), .count(count), .overflow(overflow),
        .coll_seen(coll_seen), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && pop && q_valid && !arm) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h expected=none", {q_time, q_addr, q_data});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({q_time, q_addr, q_data} !== e) begin
                    failures++;
                    $display("FAIL pop_entry actual=%0h expected=%0h", {q_time, q_addr, q_data}, e);
                end
            end
        end
    end

    // One clock: inputs are sampled at the posedge, then single-cycle inputs drop.
    task automatic cyc();
        @(posedge clk);
        #1;
        arm = 1'b0; trig = 1'b0; lbo_write = 1'b0; pop = 1'b0; collision = 1'b0;
    endtask

    // Drive a write; expect it in the FIFO with timestamp t when keep is set.
    task automatic wr(input logic [15:0] t, input logic [15:0] a, input logic [31:0] d,
                      input bit keep);
        lbo_write = 1'b1; lbo_addr = a; lbo_data = d;
        if (keep) exp_q.push_back({t, a, d});
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        exp_q.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            pop = 1'b1;
            cyc();
        end
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_q_valid", 64'(q_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_coll_seen", 64'(coll_seen), 64'd0);
        chk("rst_head", {q_time, q_addr, q_data}, 64'd0);

        // Window of 100 cycles, writes at T+0, T+5, T+100, T+101.
        do_arm();
        chk("arm_state", 64'(state), 64'd1);
        trig = 1'b1; win_len = 16'd100; wr(16'd0, 16'h1000, 32'hA000_0000, 1'b1);
        cyc();
        chk("t1_capture", 64'(state), 64'd2);
        repeat (4) cyc();
        wr(16'd5, 16'h1005, 32'hA000_0005, 1'b1);
        cyc();
        repeat (94) cyc();
        wr(16'd100, 16'h1064, 32'hA000_0064, 1'b1);
        cyc();
        chk("t1_done", 64'(state), 64'd3);
        wr(16'd101, 16'h1065, 32'hA000_0065, 1'b0);
        cyc();
        chk("t1_count", 64'(count), 64'd3);
        drain(3);
        chk("t1_empty", 64'(q_valid), 64'd0);

        // Six writes into a four-deep FIFO without popping.
        do_arm();
        trig = 1'b1; win_len = 16'd20;
        for (int i = 0; i < 6; i++) begin
            wr(16'(i), 16'(16'h2000 + i), 32'(32'hB000_0000 + i), i < 4);
            cyc();
        end
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_overflow", 64'(overflow), 64'd1);
        drain(4);
        chk("t2_empty", 64'(count), 64'd0);

        // Full FIFO, then push and pop in the same cycle.
        do_arm();
        chk("t3_ovf_cleared", 64'(overflow), 64'd0);
        trig = 1'b1; win_len = 16'd20;
        for (int i = 0; i < 4; i++) begin
            wr(16'(i), 16'(16'h3000 + i), 32'(32'hC000_0000 + i), 1'b1);
            cyc();
        end
        chk("t3_full", 64'(count), 64'd4);
        wr(16'd4, 16'h3004, 32'hC000_0004, 1'b1);
        pop = 1'b1;
        cyc();
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd0);
        drain(4);
        chk("t3_empty", 64'(q_valid), 64'd0);

        // Pop on empty, then arm during CAPTURE with three entries held.
        do_arm();
        pop = 1'b1;
        cyc();
        chk("t4_pop_empty_valid", 64'(q_valid), 64'd0);
        chk("t4_pop_empty_count", 64'(count), 64'd0);
        trig = 1'b1; win_len = 16'd50;
        for (int i = 0; i < 3; i++) begin
            wr(16'(i), 16'(16'h4000 + i), 32'(32'hD000_0000 + i), 1'b1);
            cyc();
        end
        chk("t4_held", 64'(count), 64'd3);
        arm = 1'b1; pop = 1'b1; lbo_write = 1'b1;
        cyc();
        exp_q.delete();
        chk("t4_state", 64'(state), 64'd1);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_valid", 64'(q_valid), 64'd0);

        // Collision in ARMED is ignored; in CAPTURE it is sticky until the next arm.
        collision = 1'b1;
        cyc();
        chk("t5_armed_coll", 64'(coll_seen), 64'd0);
        trig = 1'b1; win_len = 16'd10;
        cyc();
        collision = 1'b1;
        cyc();
        chk("t5_capture_coll", 64'(coll_seen), 64'd1);
        do_arm();
        chk("t5_coll_cleared", 64'(coll_seen), 64'd0);

        // Zero-length window: trigger-cycle write only, then DONE.
        trig = 1'b1; win_len = 16'd0; wr(16'd0, 16'h5000, 32'hE000_0000, 1'b1);
        cyc();
        chk("t6_state", 64'(state), 64'd3);
        chk("t6_count", 64'(count), 64'd1);
        trig = 1'b1; wr(16'd0, 16'h5001, 32'hE000_0001, 1'b0);
        cyc();
        chk("t6_done_ignored", 64'(count), 64'd1);
        drain(1);
        chk("t6_empty", 64'(q_valid), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
